// File: rtl/divider_multi_pkg.sv
// Shared types and helpers for the multi-radix restoring divider.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOOP  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } div_state_t;

  // Widest operand the helpers below are written for.
  localparam int DIV_MAX_W = 64;

  // Legal configuration: at least 2 bits, and the radix must retire whole
  // iterations so the loop count is an integer.
  function automatic bit div_width_ok(input int n_bits, input int bpc);
    return (n_bits >= 2) && (n_bits <= DIV_MAX_W) && (bpc >= 1) &&
           ((n_bits % bpc) == 0);
  endfunction

  // Quotient reported for a divide by zero: all ones in the low 'width' bits.
  function automatic logic [DIV_MAX_W-1:0] div_zero_quotient(input int width);
    logic [DIV_MAX_W-1:0] pattern;
    pattern = '0;
    for (int i = 0; i < DIV_MAX_W; i++) begin
      if (i < width) pattern[i] = 1'b1;
    end
    return pattern;
  endfunction

endpackage

// File: rtl/divider_multi_step.sv
// One combinational restoring-division iteration.
// rem holds {partial remainder, remaining dividend bits}; each step shifts it
// left by one, trial-subtracts the divisor from the upper half and appends the
// resulting quotient bit to quo.
module divider_step #(
  parameter int N_BITS = 16
) (
  input  logic [2*N_BITS-1:0] rem,
  input  logic [N_BITS-1:0]   den,
  input  logic [N_BITS-1:0]   quo,
  output logic [2*N_BITS-1:0] rem_next,
  output logic [N_BITS-1:0]   quo_next
);

  logic [2*N_BITS-1:0] rem_shift;
  logic                carry;
  logic [N_BITS-1:0]   upper;
  logic [N_BITS-1:0]   diff;
  logic                fits;

  // Shift, trial subtract, keep or restore. The shifted-out MSB (carry) makes
  // the trial value N_BITS+1 wide; when it is set the subtraction always fits
  // and the true difference is below den, so the wrapped N-bit diff is exact.
  always_comb begin
    rem_shift = rem << 1;
    carry     = rem[2*N_BITS-1];
    upper     = rem_shift[2*N_BITS-1:N_BITS];
    diff      = upper - den;
    fits      = carry | (upper >= den);
    rem_next  = fits ? {diff, rem_shift[N_BITS-1:0]} : rem_shift;
    quo_next  = (quo << 1) | {{(N_BITS-1){1'b0}}, fits};
  end

endmodule

// File: rtl/divider_multi.sv
// Sequential restoring divider with valid/ready handshakes, signed/unsigned
// operands and BITS_PER_CYCLE quotient bits retired per LOOP cycle.
// Optional build macro DIVIDER_MULTI_EARLY_EXIT_EN: when |num| < |den| the
// loop is skipped and the result is produced with the divide-by-zero latency.
//
// state | meaning
// IDLE  | ready for operands; in_ready high
// LOOP  | BITS_PER_CYCLE restoring steps per cycle on magnitudes
// FIXUP | apply operand signs, register result
// DONE  | result held with out_valid until out_ready
module divider_multi
  import divider_pkg::*;
#(
  parameter int N_BITS         = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] numerator,
  input  logic [N_BITS-1:0] denominator,
  input  logic              is_signed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_BITS-1:0] quotient,
  output logic [N_BITS-1:0] remainder,
  output logic              div_by_zero
);

  if (!div_width_ok(N_BITS, BITS_PER_CYCLE)) begin : g_bad_cfg
    $error("divider_multi: N_BITS must be >= 2 and a multiple of BITS_PER_CYCLE");
  end

  localparam int ITERS = N_BITS / BITS_PER_CYCLE;
  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [DIV_MAX_W-1:0] DBZ_Q_FULL = div_zero_quotient(N_BITS);
  localparam logic [N_BITS-1:0] DBZ_Q = DBZ_Q_FULL[N_BITS-1:0];

  div_state_t state;
  div_state_t state_next;

  logic [CNT_W-1:0]    cnt;
  logic [2*N_BITS-1:0] rem_acc;
  logic [N_BITS-1:0]   quo_acc;
  logic [N_BITS-1:0]   den_mag;
  logic                neg_num;
  logic                neg_den;
  logic                dbz;

  logic [N_BITS-1:0]   num_mag_in;
  logic [N_BITS-1:0]   den_mag_in;
  logic                den_zero;
  logic                early_exit;
  logic                accept;
  logic                neg_quo;
  logic                neg_rem;
  logic [N_BITS-1:0]   rem_mag;

  logic [2*N_BITS-1:0] r_chain [BITS_PER_CYCLE+1];
  logic [N_BITS-1:0]   q_chain [BITS_PER_CYCLE+1];

  // Operand magnitudes and accept-time decisions, taken straight off the ports.
  always_comb begin
    num_mag_in = (is_signed && numerator[N_BITS-1])   ? -numerator   : numerator;
    den_mag_in = (is_signed && denominator[N_BITS-1]) ? -denominator : denominator;
    den_zero   = (denominator == '0);
    in_ready   = (state == IDLE) && !rst;
    accept     = in_valid && in_ready;
  end

`ifdef DIVIDER_MULTI_EARLY_EXIT_EN
  assign early_exit = !den_zero && (num_mag_in < den_mag_in);
`else
  assign early_exit = 1'b0;
`endif

  assign r_chain[0] = rem_acc;
  assign q_chain[0] = quo_acc;

  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    divider_step #(
      .N_BITS(N_BITS)
    ) u_step (
      .rem      (r_chain[g]),
      .den      (den_mag),
      .quo      (q_chain[g]),
      .rem_next (r_chain[g+1]),
      .quo_next (q_chain[g+1])
    );
  end

  // Sign fixup: quotient negative when signs differ, remainder follows the
  // dividend; a divide by zero reports its raw numerator untouched.
  always_comb begin
    neg_quo = (neg_num ^ neg_den) && !dbz;
    neg_rem = neg_num && !dbz;
    rem_mag = rem_acc[2*N_BITS-1:N_BITS];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (den_zero || early_exit) state_next = FIXUP;
          else                        state_next = LOOP;
        end
      end
      LOOP: begin
        if (cnt == '0) state_next = FIXUP;
      end
      FIXUP: state_next = DONE;
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      rem_acc     <= '0;
      quo_acc     <= '0;
      den_mag     <= '0;
      neg_num     <= 1'b0;
      neg_den     <= 1'b0;
      dbz         <= 1'b0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            neg_num <= is_signed & numerator[N_BITS-1];
            neg_den <= is_signed & denominator[N_BITS-1];
            den_mag <= den_mag_in;
            cnt     <= CNT_LAST;
            dbz     <= den_zero;
            if (den_zero) begin
              quo_acc <= DBZ_Q;
              rem_acc <= {numerator, {N_BITS{1'b0}}};
            end else if (early_exit) begin
              quo_acc <= '0;
              rem_acc <= {num_mag_in, {N_BITS{1'b0}}};
            end else begin
              quo_acc <= '0;
              rem_acc <= {{N_BITS{1'b0}}, num_mag_in};
            end
          end
        end
        LOOP: begin
          rem_acc <= r_chain[BITS_PER_CYCLE];
          quo_acc <= q_chain[BITS_PER_CYCLE];
          if (cnt != '0) cnt <= cnt - CNT_ONE;
        end
        FIXUP: begin
          quotient    <= neg_quo ? -quo_acc : quo_acc;
          remainder   <= neg_rem ? -rem_mag : rem_mag;
          div_by_zero <= dbz;
          out_valid   <= 1'b1;
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: doc/divider_multi.md
Name: divider_multi

Overview:
- Parametrised sequential restoring divider; successor to the single-bit-per-cycle start/busy divider.
- Adds valid/ready handshakes on input and output, full signed mode for both operands, and configurable radix (bits retired per cycle).
- Adds defined divide-by-zero and signed-overflow results.
- Sits between raster/geometry math and consumers: slope, texture-step and perspective divides.

Parameters:
- N_BITS, 16, operand/result width; must be >= 2.
- BITS_PER_CYCLE, 1, quotient bits retired per LOOP cycle; must divide N_BITS (elaboration error otherwise).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  high only in IDLE; transfer when in_valid && in_ready.
- numerator  input  N_BITS  dividend.
- denominator  input  N_BITS  divisor.
- is_signed  input  1  1: both operands two's complement; 0: unsigned.
- out_valid  output  1  result held valid until accepted.
- out_ready  input  1  consumer accepts; transfer when out_valid && out_ready.
- quotient  output  N_BITS  result quotient.
- remainder  output  N_BITS  result remainder.
- div_by_zero  output  1  flags the current result as a divide by zero; qualified by out_valid.

Behaviour:
- Reset: state=IDLE; out_valid=0; quotient=0; remainder=0; div_by_zero=0; in_ready=1 from the first cycle after rst deasserts.
- rst mid-operation aborts immediately. Any held result is dropped. No out_valid pulse follows.
- States: IDLE, LOOP, FIXUP, DONE. The enum is 2 bits.
- IDLE:
  - On input transfer, capture operands, is_signed and operand sign bits.
  - Convert negative operands to magnitudes (signed mode).
  - Load iteration counter with N_BITS/BITS_PER_CYCLE-1.
  - Go to LOOP. If denominator==0, go to FIXUP directly with the zero flag set.
- LOOP:
  - Perform BITS_PER_CYCLE restoring steps per cycle: shift R left 1, trial subtract D, set Q bit if non-negative, else restore.
  - R is 2*N_BITS wide.
  - When counter==0, go to FIXUP; otherwise decrement.
- FIXUP (one cycle): apply signs and register the outputs.
  - Quotient is negated iff is_signed and operand signs differ.
  - Remainder is negated iff is_signed and numerator negative (truncate toward zero; remainder sign follows dividend).
  - Go to DONE with out_valid=1.
- DONE: hold all outputs stable. On out_ready, out_valid falls next cycle and state goes to IDLE. in_ready is high in that IDLE cycle; no same-cycle pass-through.
- Latency from accept to out_valid: N_BITS/BITS_PER_CYCLE + 2 cycles (N_BITS=16, BPC=1: 18). Divide-by-zero: 2 cycles.
- Divide by zero: quotient = all ones; remainder = original numerator (unconverted); div_by_zero=1.
- Signed overflow (most-negative / -1):
  - quotient = most-negative (wraps); remainder = 0; div_by_zero=0.
  - Falls out of magnitude arithmetic; no special case required, but it must hold.
- in_valid while busy is ignored; operand inputs may change freely after the accept cycle.

Optional Feature:
- Macro DIVIDER_MULTI_EARLY_EXIT_EN.
- Defined: in IDLE, if |numerator| < |denominator| (magnitudes) and denominator!=0, skip LOOP and go to FIXUP with Q=0 and R=|numerator|. Latency 2 cycles; results are identical after sign fixup.
- Undefined: every nonzero divide takes the full fixed latency (deterministic timing).

Decomposition:
- Package divider_pkg holds:
  - the state enum typedef div_state_t (IDLE, LOOP, FIXUP, DONE);
  - a width-check helper function (N_BITS % BITS_PER_CYCLE == 0);
  - the divide-by-zero quotient constant pattern, as a function of width.
- Sub-module divider_step: one combinational restoring iteration (inputs R, D, Q; outputs R', Q').
- The top instantiates divider_step BITS_PER_CYCLE times in a generate chain.

Test Plan:
- Unsigned, N_BITS=16: 1000/7 -> q=142, r=6, div_by_zero=0, out_valid exactly 18 cycles after accept.
- Signed: -7/2 -> q=-3 (0xFFFD), r=-1. 7/-2 -> q=-3, r=1. -7/-2 -> q=3, r=-1.
- Divide by zero, signed, 0x1234/0 -> q=0xFFFF, r=0x1234, div_by_zero=1, latency 2. Overflow 0x8000/0xFFFF signed -> q=0x8000, r=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0, new in_valid ignored. Release -> in_ready=1 next cycle.
- rst asserted mid-LOOP (cycle 5) -> next cycle state IDLE, out_valid=0, in_ready=1. Following 100/10 returns q=10, r=0.
- BITS_PER_CYCLE=4, N_BITS=16, random unsigned/signed sweep vs reference model. Latency 6; early-exit build: 3/200 returns q=0, r=3 in 2 cycles.
